// File: rtl/router_reg.sv
// Router datapath register stage: latches header/payload bytes for the output FIFO,
// buffers a byte across a FIFO-full stall, and checks running XOR parity.
module router_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_packet_valid,
    output logic             err
);

    logic [WIDTH-1:0] hdr;
    logic [WIDTH-1:0] hold;
    logic             hold_is_par;
    logic [WIDTH-1:0] int_par;
    logic [WIDTH-1:0] pkt_par;
    logic             chk;

    always_ff @(posedge clock) begin
        if (reset) begin
            dout             <= '0;
            hdr              <= '0;
            hold             <= '0;
            hold_is_par      <= 1'b0;
            int_par          <= '0;
            pkt_par          <= '0;
            parity_done      <= 1'b0;
            low_packet_valid <= 1'b0;
            err              <= 1'b0;
            chk              <= 1'b0;
        end else begin
            // Packet start: capture header (address 3 is not a valid port) and clear status
            if (detect_add && pkt_valid) begin
                if (data_in[1:0] != 2'b11) begin
                    hdr <= data_in;
                end
                parity_done <= 1'b0;
                err         <= 1'b0;
                chk         <= 1'b0;
            end else begin
                chk <= parity_done & ~chk;
                if (parity_done && !chk) begin
                    err <= (int_par != pkt_par);
                end
            end

            if (lfd_state) begin
                dout    <= hdr;
                int_par <= hdr;
            end else if (ld_state) begin
                if (!fifo_full) begin
                    dout <= data_in;
                    if (pkt_valid) begin
                        int_par <= int_par ^ data_in;
                    end else begin
                        pkt_par     <= data_in;
                        parity_done <= 1'b1;
                    end
                end else begin
                    // FIFO stalled: park the byte and remember whether it is the parity byte
                    hold        <= data_in;
                    hold_is_par <= ~pkt_valid;
                end
            end else if (full_state) begin
                hold <= hold;
            end else if (laf_state) begin
                dout <= hold;
                if (hold_is_par) begin
                    pkt_par     <= hold;
                    parity_done <= 1'b1;
                end else begin
                    int_par <= int_par ^ hold;
                end
            end

            if (ld_state && !pkt_valid) begin
                low_packet_valid <= 1'b1;
            end else if (rst_int_reg) begin
                low_packet_valid <= 1'b0;
            end
        end
    end

endmodule
